axi3_mem_slave: RTL and testbench



---
 rtl/axi3_pkg.sv | 42 ++++
 rtl/axi3_addr_gen.sv | 28 ++
 rtl/axi3_mem_slave.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_axi3_mem_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_pkg.sv
// Shared types, response codes and request legality check for the AXI3 memory slave.
package axi3_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_t;

   // A request is illegal for a reserved burst type, a transfer wider than the
   // 32-bit bus, or a WRAP burst with a bad length or a misaligned start address.
   function automatic logic burst_legal(input logic [31:0] addr,
                                        input logic [3:0]  len,
                                        input logic [2:0]  size,
                                        input logic [1:0]  burst);
      logic ok;
      ok = 1'b1;
      if (burst == 2'b11) ok = 1'b0;
      if (size > 3'd2) ok = 1'b0;
      if (burst == BURST_WRAP) begin
         if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) ok = 1'b0;
         if (size == 3'd1 && addr[0]) ok = 1'b0;
         if (size == 3'd2 && addr[1:0] != 2'b00) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/axi3_addr_gen.sv
// Next-beat byte address for FIXED, INCR and WRAP bursts.
module axi3_addr_gen
   import axi3_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [3:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr
);

   logic [31:0] step;
   logic [31:0] wrap_mask;

   // WRAP keeps the upper bits of the boundary-aligned window and lets only the
   // low bits inside the window advance and roll over.
   always_comb begin
      step      = 32'd1 << size;
      wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      next_addr = addr;
      if (burst == BURST_INCR) begin
         next_addr = addr + step;
      end else if (burst == BURST_WRAP) begin
         next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      end
   end

endmodule

// File: rtl/axi3_mem_slave.sv
// Memory-backed AXI3 slave with independent write and read burst engines.
module axi3_mem_slave
   import axi3_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  AWID,
   input  logic [31:0] AWADDR,
   input  logic [3:0]  AWLEN,
   input  logic [2:0]  AWSIZE,
   input  logic [1:0]  AWBURST,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [3:0]  WID,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [3:0]  BID,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   input  logic [3:0]  ARID,
   input  logic [31:0] ARADDR,
   input  logic [3:0]  ARLEN,
   input  logic [2:0]  ARSIZE,
   input  logic [1:0]  ARBURST,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [3:0]  RID,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];

   function automatic logic in_range(input logic [31:0] a);
      return {2'b00, a[31:2]} < 32'(DEPTH);
   endfunction

   // write path state
   wstate_t     w_state_q, w_state_d;
   logic [3:0]  awid_q, awid_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [3:0]  w_len_q, w_len_d, w_count_q, w_count_d;
   logic [2:0]  w_size_q, w_size_d;
   logic [1:0]  w_burst_q, w_burst_d;
   logic        w_legal_q, w_legal_d, w_err_q, w_err_d;
   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [3:0]  bid_q, bid_d;
   logic [31:0] wr_next;
   logic        wr_last, beat_err, mem_we;

   // read path state
   rstate_t     r_state_q, r_state_d;
   logic [3:0]  rid_q, rid_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [3:0]  r_len_q, r_len_d, r_count_q, r_count_d;
   logic [2:0]  r_size_q, r_size_d;
   logic [1:0]  r_burst_q, r_burst_d;
   logic        r_legal_q, r_legal_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rd_cur_addr, rd_next, rd_word;
   logic [3:0]  rd_len;
   logic [2:0]  rd_size;
   logic [1:0]  rd_burst;
   logic        rd_legal, rd_ok;

   axi3_addr_gen u_wr_addr (
      .addr      (w_addr_q),
      .len       (w_len_q),
      .size      (w_size_q),
      .burst     (w_burst_q),
      .next_addr (wr_next)
   );

   axi3_addr_gen u_rd_addr (
      .addr      (rd_cur_addr),
      .len       (rd_len),
      .size      (rd_size),
      .burst     (rd_burst),
      .next_addr (rd_next)
   );

   // Write engine: capture the AW request, absorb beats until the counted last one, then respond.
   always_comb begin
      w_state_d = w_state_q;
      awid_d    = awid_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_count_d = w_count_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_legal_d = w_legal_q;
      w_err_d   = w_err_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      wr_last   = (w_count_q == w_len_q);
      beat_err  = !in_range(w_addr_q) || (WLAST != wr_last);
      mem_we    = (w_state_q == W_DATA) && WVALID && w_legal_q && in_range(w_addr_q);
      case (w_state_q)
         W_IDLE: begin
            if (AWVALID && awready_q) begin
               w_state_d = W_DATA;
               awid_d    = AWID;
               w_addr_d  = AWADDR;
               w_len_d   = AWLEN;
               w_size_d  = AWSIZE;
               w_burst_d = AWBURST;
               w_legal_d = burst_legal(AWADDR, AWLEN, AWSIZE, AWBURST);
               w_err_d   = !burst_legal(AWADDR, AWLEN, AWSIZE, AWBURST);
               w_count_d = 4'd0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
            end
         end
         W_DATA: begin
            if (WVALID) begin
               w_addr_d  = wr_next;
               w_count_d = w_count_q + 4'd1;
               if (beat_err) w_err_d = 1'b1;
               if (wr_last) begin
                  w_state_d = W_RESP;
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = (w_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                  bid_d     = awid_q;
               end
            end
         end
         W_RESP: begin
            if (BREADY) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write engine registers; outputs come straight from these flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         awid_q    <= 4'd0;
         w_addr_q  <= 32'd0;
         w_len_q   <= 4'd0;
         w_count_q <= 4'd0;
         w_size_q  <= 3'd0;
         w_burst_q <= 2'd0;
         w_legal_q <= 1'b0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= 4'd0;
      end else begin
         w_state_q <= w_state_d;
         awid_q    <= awid_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_count_q <= w_count_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_legal_q <= w_legal_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
      end
   end

   // Byte-lane memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (WSTRB[b]) mem[w_addr_q[2 +: AW]][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // In idle the read address generator looks at the incoming AR so beat 0 and
   // its successor address are ready at the handshake edge.
   always_comb begin
      rd_cur_addr = (r_state_q == R_IDLE) ? ARADDR  : r_addr_q;
      rd_len      = (r_state_q == R_IDLE) ? ARLEN   : r_len_q;
      rd_size     = (r_state_q == R_IDLE) ? ARSIZE  : r_size_q;
      rd_burst    = (r_state_q == R_IDLE) ? ARBURST : r_burst_q;
      rd_legal    = (r_state_q == R_IDLE) ? burst_legal(ARADDR, ARLEN, ARSIZE, ARBURST) : r_legal_q;
      rd_ok       = rd_legal && in_range(rd_cur_addr);
      rd_word     = rd_ok ? mem[rd_cur_addr[2 +: AW]] : 32'd0;
   end

   // Read engine: present one registered beat at a time, advancing on each accepted beat.
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_count_d = r_count_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_legal_d = r_legal_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ARVALID && arready_q) begin
               r_state_d = R_DATA;
               rid_d     = ARID;
               r_len_d   = ARLEN;
               r_size_d  = ARSIZE;
               r_burst_d = ARBURST;
               r_legal_d = rd_legal;
               r_count_d = 4'd0;
               r_addr_d  = rd_next;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = rd_word;
               rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
               rlast_d   = (ARLEN == 4'd0);
            end
         end
         R_DATA: begin
            if (RREADY) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
               end else begin
                  r_count_d = r_count_q + 4'd1;
                  r_addr_d  = rd_next;
                  rdata_d   = rd_word;
                  rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                  rlast_d   = ((r_count_q + 4'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read engine registers; outputs come straight from these flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         rid_q     <= 4'd0;
         r_addr_q  <= 32'd0;
         r_len_q   <= 4'd0;
         r_count_q <= 4'd0;
         r_size_q  <= 3'd0;
         r_burst_q <= 2'd0;
         r_legal_q <= 1'b0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_count_q <= r_count_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_legal_q <= r_legal_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign BID     = bid_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RID     = rid_q;

endmodule

// File: tb/tb_axi3_mem_slave.sv
// Directed bench for the AXI3 memory slave: bursts, wrap, strobes, errors, stalls, reset.
module tb_axi3_mem_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  AWID, WID, ARID, BID, RID;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [3:0]  AWLEN, ARLEN, WSTRB;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb;
   logic        wlast_bad;
   logic [1:0]  wr_bresp;
   logic [3:0]  wr_bid;
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id   [16];
   logic [31:0] exp_data [16];
   logic [1:0]  exp_resp [16];

   axi3_mem_slave #(.DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_awready"}, AWREADY, 1);
      check({pfx, "_arready"}, ARREADY, 1);
      check({pfx, "_wready"},  WREADY,  0);
      check({pfx, "_bvalid"},  BVALID,  0);
      check({pfx, "_rvalid"},  RVALID,  0);
      check({pfx, "_rlast"},   RLAST,   0);
      check({pfx, "_bresp"},   BRESP,   0);
      check({pfx, "_rresp"},   RRESP,   0);
      check({pfx, "_bid"},     BID,     0);
      check({pfx, "_rid"},     RID,     0);
      check({pfx, "_rdata"},   RDATA,   0);
   endtask

   // Full write burst of 32-bit beats from wr_data, BREADY held off for bdelay cycles.
   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst, input int bdelay);
      int k;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
      k = 0;
      while (!AWREADY && k < 50) begin @(posedge clk); #1; k++; end
      check("awready", AWREADY, 1);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      check("awready_low_during_data", AWREADY, 0);
      for (int i = 0; i <= int'(len); i++) begin
         WID = id; WDATA = wr_data[i]; WSTRB = wr_strb; WVALID = 1'b1;
         WLAST = (i == int'(len)) ^ (wlast_bad && i == 0);
         k = 0;
         while (!WREADY && k < 50) begin @(posedge clk); #1; k++; end
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      check("bvalid_after_last_w", BVALID, 1);
      for (int d = 0; d < bdelay; d++) begin @(posedge clk); #1; end
      check("bvalid_held", BVALID, 1);
      wr_bresp = BRESP; wr_bid = BID;
      BREADY = 1'b1;
      @(posedge clk); #1;
      BREADY = 1'b0;
      check("bvalid_cleared", BVALID, 0);
      check("awready_back", AWREADY, 1);
   endtask

   // Read burst collecting beats; with rand_ready, stalled outputs must hold steady.
   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] burst, input bit rand_ready);
      int k, beat;
      logic stalled;
      logic [31:0] hd;
      logic [1:0] hr;
      logic hl;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
      k = 0;
      while (!ARREADY && k < 50) begin @(posedge clk); #1; k++; end
      check("arready", ARREADY, 1);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      check("rvalid_after_ar", RVALID, 1);
      beat = 0; k = 0;
      while (beat <= int'(len) && k < 300) begin
         RREADY  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = RVALID && !RREADY;
         hd = RDATA; hr = RRESP; hl = RLAST;
         if (RVALID && RREADY) begin
            rd_data[beat] = RDATA; rd_resp[beat] = RRESP;
            rd_last[beat] = RLAST; rd_id[beat] = RID;
            beat++;
         end
         @(posedge clk); #1;
         k++;
         if (stalled) begin
            check("rvalid_stalled", RVALID, 1);
            check("rdata_stable", RDATA, hd);
            check("rresp_stable", RRESP, hr);
            check("rlast_stable", RLAST, hl);
         end
      end
      RREADY = 1'b0;
      check("read_beat_count", beat, 32'(len) + 32'd1);
      check("arready_after_last", ARREADY, 1);
      check("rvalid_after_last", RVALID, 0);
   endtask

   task automatic check_read(input string name, input logic [3:0] id, input logic [3:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         check($sformatf("%s_rdata[%0d]", name, i), rd_data[i], exp_data[i]);
         check($sformatf("%s_rresp[%0d]", name, i), rd_resp[i], exp_resp[i]);
         check($sformatf("%s_rlast[%0d]", name, i), rd_last[i], (i == int'(len)) ? 1 : 0);
         check($sformatf("%s_rid[%0d]", name, i),   rd_id[i],   id);
      end
   endtask

   initial begin
      reset = 1'b1;
      AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
      WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
      ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
      wr_strb = 4'hF; wlast_bad = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b0;
      @(posedge clk); #1;

      // INCR write then INCR read back with a random RREADY, BREADY delayed 5 cycles
      for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
      write_burst(4'd5, 32'h10, 4'd3, 2'b01, 5);
      check("incr_wr_bresp", wr_bresp, 2'b00);
      check("incr_wr_bid", wr_bid, 4'd5);
      for (int i = 0; i < 4; i++) begin exp_data[i] = 32'hA0 + 32'(i); exp_resp[i] = 2'b00; end
      read_burst(4'd9, 32'h10, 4'd3, 2'b01, 1'b1);
      check_read("incr", 4'd9, 4'd3);

      // WRAP read starting mid-window: 0x38, 0x3C, 0x30, 0x34
      for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0 + 32'(i);
      write_burst(4'd6, 32'h30, 4'd3, 2'b01, 0);
      check("wrap_setup_bresp", wr_bresp, 2'b00);
      exp_data[0] = 32'hB2; exp_data[1] = 32'hB3; exp_data[2] = 32'hB0; exp_data[3] = 32'hB1;
      read_burst(4'd10, 32'h38, 4'd3, 2'b10, 1'b0);
      check_read("wrap", 4'd10, 4'd3);

      // Byte strobes 0101 over 0x12345678
      wr_data[0] = 32'h12345678;
      write_burst(4'd1, 32'h40, 4'd0, 2'b01, 0);
      wr_data[0] = 32'hFFFFFFFF; wr_strb = 4'b0101;
      write_burst(4'd1, 32'h40, 4'd0, 2'b01, 0);
      wr_strb = 4'hF;
      exp_data[0] = 32'h12FF56FF; exp_resp[0] = 2'b00;
      read_burst(4'd2, 32'h40, 4'd0, 2'b01, 1'b0);
      check_read("strobe", 4'd2, 4'd0);

      // Read crossing the top of memory: words 254, 255 valid, 256, 257 out of range
      wr_data[0] = 32'hC0; wr_data[1] = 32'hC1;
      write_burst(4'd2, 32'h3F8, 4'd1, 2'b01, 0);
      check("top_wr_bresp", wr_bresp, 2'b00);
      exp_data[0] = 32'hC0; exp_data[1] = 32'hC1; exp_data[2] = 32'h0; exp_data[3] = 32'h0;
      exp_resp[0] = 2'b00;  exp_resp[1] = 2'b00;  exp_resp[2] = 2'b10; exp_resp[3] = 2'b10;
      read_burst(4'd3, 32'h3F8, 4'd3, 2'b01, 1'b0);
      check_read("oor", 4'd3, 4'd3);

      // Reserved burst type: SLVERR and memory untouched
      wr_data[0] = 32'hDEADBEEF;
      write_burst(4'd4, 32'h10, 4'd0, 2'b11, 0);
      check("illegal_bresp", wr_bresp, 2'b10);
      check("illegal_bid", wr_bid, 4'd4);
      exp_data[0] = 32'hA0; exp_resp[0] = 2'b00;
      read_burst(4'd4, 32'h10, 4'd0, 2'b01, 1'b0);
      check_read("illegal_mem", 4'd4, 4'd0);

      // Early WLAST flags an error
      wlast_bad = 1'b1;
      wr_data[0] = 32'hF0; wr_data[1] = 32'hF1;
      write_burst(4'd7, 32'h60, 4'd1, 2'b01, 0);
      wlast_bad = 1'b0;
      check("wlast_bresp", wr_bresp, 2'b10);

      // Concurrent write and read bursts
      for (int i = 0; i < 4; i++) begin
         wr_data[i] = 32'hD0 + 32'(i);
         exp_data[i] = 32'hA0 + 32'(i); exp_resp[i] = 2'b00;
      end
      fork
         write_burst(4'd8, 32'h80, 4'd3, 2'b01, 2);
         begin
            read_burst(4'd11, 32'h10, 4'd3, 2'b01, 1'b1);
            check_read("conc_rd", 4'd11, 4'd3);
         end
      join
      check("conc_wr_bresp", wr_bresp, 2'b00);
      check("conc_wr_bid", wr_bid, 4'd8);
      for (int i = 0; i < 4; i++) exp_data[i] = 32'hD0 + 32'(i);
      read_burst(4'd11, 32'h80, 4'd3, 2'b01, 1'b0);
      check_read("conc_back", 4'd11, 4'd3);

      // Reset after two of four write beats
      AWID = 4'd3; AWADDR = 32'h100; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      check("rst_aw_ready", AWREADY, 1);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; WDATA = 32'hE0;
      @(posedge clk); #1;
      WDATA = 32'hE1;
      @(posedge clk); #1;
      WVALID = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      reset = 1'b0;
      @(posedge clk); #1;
      exp_data[0] = 32'hE0; exp_data[1] = 32'hE1; exp_resp[0] = 2'b00; exp_resp[1] = 2'b00;
      read_burst(4'd13, 32'h100, 4'd1, 2'b01, 1'b0);
      check_read("rst_kept", 4'd13, 4'd1);
      wr_data[0] = 32'h55; wr_data[1] = 32'h66;
      write_burst(4'd12, 32'h100, 4'd1, 2'b01, 0);
      check("post_rst_bresp", wr_bresp, 2'b00);
      check("post_rst_bid", wr_bid, 4'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
